// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode/funct constants, ALU function codes and the control-word struct.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // States that stall on mem_ready and are covered by the bus timeout.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Control/status bundle between the multi-cycle control unit (master) and
// the shared-memory datapath (slave).
interface mc_if #(
  parameter int ALUF_W = 5
);
  logic [5:0]        op;
  logic [5:0]        fun;
  logic              zero;
  logic              mem_ready;
  logic              pc_wr;
  logic              ir_wr;
  logic              iord;
  logic              mem_rd;
  logic              mem_wr;
  logic              reg_wr;
  logic [1:0]        reg_dst;
  logic [1:0]        mem_to_reg;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic              ext_op;
  logic [1:0]        pc_src;
  logic [ALUF_W-1:0] aluf;
  logic [3:0]        state_o;
  logic              illegal;
  logic              bus_err;

  modport master (
    input  op, fun, zero, mem_ready,
    output pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, ext_op, pc_src, aluf, state_o, illegal, bus_err
  );

  modport slave (
    output op, fun, zero, mem_ready,
    input  pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, ext_op, pc_src, aluf, state_o, illegal, bus_err
  );
endinterface

// File: rtl/mc_alu_decode.sv
// ALU function decoder: picks the ALU code for the current state from the
// funct field (R-type) or opcode (immediate ops), and flags legal ALU functs.
module mc_alu_decode
  import mc_pkg::*;
#(
  parameter int ALUF_W = 5
) (
  input  logic [5:0]        op,
  input  logic [5:0]        fun,
  input  state_e            state,
  output logic [ALUF_W-1:0] aluf,
  output logic              fun_legal
);

  alu_op_e fun_code;
  alu_op_e imm_code;
  alu_op_e code;

  // NOTE: every variable gets a default first so no path leaves a latch.
  always_comb begin
    fun_code  = ALU_ADD;
    fun_legal = 1'b1;
    unique case (fun)
      FN_ADD, FN_ADDU: fun_code = ALU_ADD;
      FN_SUB, FN_SUBU: fun_code = ALU_SUB;
      FN_AND:          fun_code = ALU_AND;
      FN_OR:           fun_code = ALU_OR;
      FN_XOR:          fun_code = ALU_XOR;
      FN_NOR:          fun_code = ALU_NOR;
      FN_SLT:          fun_code = ALU_SLT;
      FN_SLTU:         fun_code = ALU_SLTU;
      FN_SLL:          fun_code = ALU_SLL;
      FN_SRL:          fun_code = ALU_SRL;
      FN_SRA:          fun_code = ALU_SRA;
      default:         fun_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_code = ALU_ADD;
    unique case (op)
      OP_SLTI: imm_code = ALU_SLT;
      OP_ANDI: imm_code = ALU_AND;
      OP_ORI:  imm_code = ALU_OR;
      OP_LUI:  imm_code = ALU_LUI;
      default: imm_code = ALU_ADD;
    endcase
  end

  always_comb begin
    code = ALU_ADD;
    unique case (state)
      S_EXEC_R: code = fun_code;
      S_EXEC_I: code = imm_code;
      S_BRANCH: code = ALU_SUB;
      default:  code = ALU_ADD;
    endcase
  end

  assign aluf = ALUF_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback, with
// mem_ready stalls, a bus-hang timeout trap and an illegal-instruction trap.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int ALUF_W      = 5,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  mc_if.master bus
);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  ctrl_t             ctrl;
  logic [ALUF_W-1:0] aluf_w;
  logic              fun_legal;
  logic              tmo_limit;
  logic [TMO_W-1:0]  tmo_inc;

  mc_alu_decode #(.ALUF_W(ALUF_W)) u_alu_decode (
    .op       (bus.op),
    .fun      (bus.fun),
    .state    (state_q),
    .aluf     (aluf_w),
    .fun_legal(fun_legal)
  );

  assign tmo_limit = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign tmo_inc   = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    ctrl      = '0;

    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ctrl.ir_wr = 1'b1;
          ctrl.pc_wr = 1'b1;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is computed here so BRANCH can load it from ALUOut.
        ctrl.alu_src_b = 2'd3;
        ctrl.ext_op    = 1'b1;
        unique case (bus.op)
          OP_RTYPE: begin
            if (bus.fun == FN_JR) state_d = S_JR;
            else if (fun_legal)   state_d = S_EXEC_R;
            else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:
                          state_d = S_EXEC_I;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        state_d        = S_WB_R;
      end

      S_WB_R: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = 2'd1;
        state_d      = S_FETCH;
      end

      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.ext_op    = !(bus.op inside {OP_ANDI, OP_ORI, OP_LUI});
        state_d        = S_WB_I;
      end

      S_WB_I: begin
        ctrl.reg_wr = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.ext_op    = 1'b1;
        state_d        = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        ctrl.mem_rd = 1'b1;
        ctrl.iord   = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end

      S_MEM_WR: begin
        ctrl.mem_wr = 1'b1;
        ctrl.iord   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_WB_MEM: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 2'd1;
        state_d         = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.pc_src    = 2'd1;
        ctrl.pc_wr     = (bus.op == OP_BEQ) ? bus.zero : !bus.zero;
        state_d        = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_src = 2'd2;
        ctrl.pc_wr  = 1'b1;
        if (bus.op == OP_JAL) begin
          ctrl.reg_wr     = 1'b1;
          ctrl.reg_dst    = 2'd2;
          ctrl.mem_to_reg = 2'd2;
        end
        state_d = S_FETCH;
      end

      S_JR: begin
        ctrl.pc_src = 2'd3;
        ctrl.pc_wr  = 1'b1;
        state_d     = S_FETCH;
      end

      default: state_d = S_TRAP;
    endcase

    // Stall accounting; a transition leaves tmo_d at its cleared default.
    if (is_wait_state(state_q) && !bus.mem_ready) begin
      tmo_d = tmo_inc;
      if (tmo_limit) begin
        state_d   = S_TRAP;
        bus_err_d = 1'b1;
      end
    end

    // NOTE: reset must silence the Moore outputs of FETCH at once, so the
    // control word is gated combinationally rather than waiting for a clock.
    if (rst) ctrl = '0;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.pc_wr      = ctrl.pc_wr;
  assign bus.ir_wr      = ctrl.ir_wr;
  assign bus.iord       = ctrl.iord;
  assign bus.mem_rd     = ctrl.mem_rd;
  assign bus.mem_wr     = ctrl.mem_wr;
  assign bus.reg_wr     = ctrl.reg_wr;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.ext_op     = ctrl.ext_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.aluf       = rst ? '0 : aluf_w;
  assign bus.state_o    = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: a per-instruction phase model predicts the
// full control word every cycle, including stalls, timeouts and traps.
module tb_multicycle_control;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_WB_R = 3,
                 P_EXEC_I = 4, P_WB_I = 5, P_MEM_ADDR = 6, P_MEM_RD = 7,
                 P_MEM_WR = 8, P_WB_MEM = 9, P_BRANCH = 10, P_JUMP = 11,
                 P_JR = 12, P_TRAP = 13;

  localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5,
                 C_I = 6, C_ILL = 7;

  localparam int LIMIT = 15;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr;
    logic [1:0] reg_dst, mem_to_reg;
    logic       a;
    logic [1:0] b;
    logic       ext;
    logic [1:0] pc_src;
    logic [4:0] aluf;
    logic       ill, berr;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_if #(.ALUF_W(5)) bus ();

  multicycle_control #(.ALUF_W(5), .TMO_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] m_op, m_fun;
  logic       m_zero;
  logic       m_ill, m_berr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  function automatic int r_alu(logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: return 0;
      6'b100010, 6'b100011: return 1;
      6'b100100: return 2;
      6'b100101: return 3;
      6'b100110: return 4;
      6'b100111: return 5;
      6'b101010: return 6;
      6'b101011: return 7;
      6'b000000: return 8;
      6'b000010: return 9;
      6'b000011: return 10;
      default:   return -1;
    endcase
  endfunction

  function automatic int classify(logic [5:0] o, logic [5:0] f);
    case (o)
      6'b000000: return (f == 6'b001000) ? C_JR : (r_alu(f) >= 0 ? C_R : C_ILL);
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010, 6'b000011: return C_J;
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001111: return C_I;
      default: return C_ILL;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s = '{bus.state_o, bus.pc_wr, bus.ir_wr, bus.iord, bus.mem_rd, bus.mem_wr,
          bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
          bus.ext_op, bus.pc_src, bus.aluf, bus.illegal, bus.bus_err};
    return s;
  endfunction

  function automatic obs_t expect_out(int ph, bit rdy);
    obs_t e;
    e      = '0;
    e.st   = 4'(ph);
    e.ill  = m_ill;
    e.berr = m_berr;
    case (ph)
      P_FETCH:    begin e.mem_rd = 1; e.b = 1; e.ir_wr = rdy; e.pc_wr = rdy; end
      P_DECODE:   begin e.b = 3; e.ext = 1; end
      P_EXEC_R:   begin e.a = 1; e.aluf = 5'(r_alu(m_fun)); end
      P_WB_R:     begin e.reg_wr = 1; e.reg_dst = 1; end
      P_EXEC_I: begin
        e.a   = 1;
        e.b   = 2;
        e.ext = !(m_op == 6'b001100 || m_op == 6'b001101 || m_op == 6'b001111);
        case (m_op)
          6'b001010: e.aluf = 6;
          6'b001100: e.aluf = 2;
          6'b001101: e.aluf = 3;
          6'b001111: e.aluf = 11;
          default:   e.aluf = 0;
        endcase
      end
      P_WB_I:     e.reg_wr = 1;
      P_MEM_ADDR: begin e.a = 1; e.b = 2; e.ext = 1; end
      P_MEM_RD:   begin e.mem_rd = 1; e.iord = 1; end
      P_MEM_WR:   begin e.mem_wr = 1; e.iord = 1; end
      P_WB_MEM:   begin e.reg_wr = 1; e.mem_to_reg = 1; end
      P_BRANCH: begin
        e.a      = 1;
        e.aluf   = 1;
        e.pc_src = 1;
        e.pc_wr  = (m_op == 6'b000100) ? m_zero : !m_zero;
      end
      P_JUMP: begin
        e.pc_src = 2;
        e.pc_wr  = 1;
        if (m_op == 6'b000011) begin e.reg_wr = 1; e.reg_dst = 2; e.mem_to_reg = 2; end
      end
      P_JR:       begin e.pc_src = 3; e.pc_wr = 1; end
      default:    ;
    endcase
    return e;
  endfunction

  // One clock of the DUT: drive at the falling edge, check, then advance.
  task automatic cycle(input string tag, input int ph, input bit rdy);
    bus.mem_ready = rdy;
    bus.zero      = m_zero;
    #1;
    check($sformatf("%s/ph%0d", tag, ph), 32'(sample()), 32'(expect_out(ph, rdy)));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.mem_ready = 1'($urandom);
    #1;
    check("reset_now", 32'(sample()), 32'd0);
    m_ill  = 1'b0;
    m_berr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(sample()), 32'd0);
    rst = 1'b0;
  endtask

  task automatic trap_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, P_TRAP, 1'($urandom));
  endtask

  // A wait phase with d not-ready cycles before mem_ready; ok=0 if it trapped.
  task automatic mem_wait(input string tag, input int ph, input int d, input int hold,
                          output bit ok);
    ok = 1'b1;
    for (int k = 0; k < LIMIT; k++) begin
      cycle(tag, ph, k == d);
      if (k == d) return;
    end
    ok     = 1'b0;
    m_berr = 1'b1;
    trap_hold({tag, "_tmo"}, hold);
    do_reset();
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op_i, input logic [5:0] fun_i,
                           input bit z, input int fd, input int md, input int hold);
    bit ok;
    m_op    = op_i;
    m_fun   = fun_i;
    m_zero  = z;
    bus.op  = op_i;
    bus.fun = fun_i;
    mem_wait(tag, P_FETCH, fd, hold, ok);
    if (!ok) return;
    cycle(tag, P_DECODE, 1'($urandom));
    case (classify(op_i, fun_i))
      C_R:  begin cycle(tag, P_EXEC_R, 1'($urandom)); cycle(tag, P_WB_R, 1'($urandom)); end
      C_JR: cycle(tag, P_JR, 1'($urandom));
      C_LW: begin
        cycle(tag, P_MEM_ADDR, 1'($urandom));
        mem_wait(tag, P_MEM_RD, md, hold, ok);
        if (ok) cycle(tag, P_WB_MEM, 1'($urandom));
      end
      C_SW: begin
        cycle(tag, P_MEM_ADDR, 1'($urandom));
        mem_wait(tag, P_MEM_WR, md, hold, ok);
      end
      C_BR: cycle(tag, P_BRANCH, 1'($urandom));
      C_J:  cycle(tag, P_JUMP, 1'($urandom));
      C_I:  begin cycle(tag, P_EXEC_I, 1'($urandom)); cycle(tag, P_WB_I, 1'($urandom)); end
      default: begin
        m_ill = 1'b1;
        trap_hold({tag, "_ill"}, hold);
        do_reset();
      end
    endcase
  endtask

  logic [5:0] op_pool [14] = '{6'b000000, 6'b000000, 6'b000000, 6'b100011, 6'b101011,
                               6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b001000,
                               6'b001010, 6'b001100, 6'b001101, 6'b001111};
  logic [5:0] fun_pool [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                6'b000000, 6'b000010, 6'b000011, 6'b001000};
  int delay_pool [8] = '{0, 0, 0, 1, 2, 3, 14, 15};

  initial begin
    logic [5:0] op_r, fun_r;
    bus.op        = '0;
    bus.fun       = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    m_op = '0; m_fun = '0; m_zero = 1'b0; m_ill = 1'b0; m_berr = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr("add",      6'b000000, 6'b100000, 1'b0, 0, 0, 3);
    run_instr("lw_stall", 6'b100011, 6'b000000, 1'b0, 0, 3, 3);
    run_instr("beq_z",    6'b000100, 6'b000000, 1'b1, 0, 0, 3);
    run_instr("bne_z",    6'b000101, 6'b000000, 1'b1, 0, 0, 3);
    run_instr("bne_nz",   6'b000101, 6'b000000, 1'b0, 1, 0, 3);
    run_instr("jal",      6'b000011, 6'b000000, 1'b0, 0, 0, 3);
    run_instr("jr",       6'b000000, 6'b001000, 1'b0, 0, 0, 3);
    run_instr("andi",     6'b001100, 6'b000000, 1'b0, 0, 0, 3);
    run_instr("illegal",  6'b111111, 6'b000000, 1'b0, 0, 0, 20);
    run_instr("bad_fun",  6'b000000, 6'b111111, 1'b0, 0, 0, 3);
    run_instr("fetch_tmo", 6'b000000, 6'b100000, 1'b0, 15, 0, 5);
    run_instr("fetch_edge", 6'b000000, 6'b100010, 1'b0, 14, 0, 5);
    run_instr("sw_tmo",   6'b101011, 6'b000000, 1'b0, 0, 15, 5);
    run_instr("sw_edge",  6'b101011, 6'b000000, 1'b0, 0, 14, 5);

    // Reset in the middle of a stalled store must drop mem_wr immediately.
    m_op = 6'b101011; m_fun = '0; m_zero = 1'b0;
    bus.op = m_op; bus.fun = m_fun;
    cycle("abort", P_FETCH, 1'b1);
    cycle("abort", P_DECODE, 1'b0);
    cycle("abort", P_MEM_ADDR, 1'b0);
    cycle("abort", P_MEM_WR, 1'b0);
    do_reset();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op_r  = 6'($urandom);
        fun_r = 6'($urandom);
      end else begin
        op_r  = op_pool[$urandom_range(0, 13)];
        fun_r = fun_pool[$urandom_range(0, 13)];
      end
      run_instr("rnd", op_r, fun_r, 1'($urandom),
                delay_pool[$urandom_range(0, 7)], delay_pool[$urandom_range(0, 7)], 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
